// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the data-memory bus controller.
// Write protection is selected by MEM_WRITE_PROTECT_EN in mem_bus_ctrl.
package mem_bus_pkg;

  localparam int          WAIT_W          = 4;
  localparam int          WAIT_CYCLES_DEF = 2;
  localparam logic [15:0] PROT_TOP_DEF    = 16'h003F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Processor-side data-memory bus: address, data, MR/MW strobes and completion status.
interface mem_bus_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              MR;
  logic              MW;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (output addr, wdata, MR, MW, input rdata, ready, busy, err);
  modport slave  (input addr, wdata, MR, MW, output rdata, ready, busy, err);
endinterface

// File: rtl/mem_array_sp.sv
// Single-port synchronous word RAM, read-during-write returns the old word.
module mem_array_sp #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus controller: accepts MR/MW, inserts WAIT_CYCLES wait states, returns ready/err.
// Define MEM_WRITE_PROTECT_EN to reject writes at or below PROT_TOP.
//
// state  | meaning
// IDLE   | sampling MR/MW; both high gives a one-cycle err
// WAIT   | wait-state down-counter running, request latched
// ACCESS | RAM write or read capture, range/protect decided
// DONE   | ready (and err if rejected) pulse, busy low
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
`ifdef MEM_WRITE_PROTECT_EN
  ,
  parameter logic [ADDR_W-1:0] PROT_TOP = ADDR_W'(PROT_TOP_DEF)
`endif
) (
  input  logic           clock,
  input  logic           reset,
  mem_bus_ctrl_if.slave  bus
);

  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);

  state_e            state;
  op_e               op_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic [WAIT_W-1:0] cnt;
  logic [DATA_W-1:0] rdata_r;
  logic              ready_r;
  logic              busy_r;
  logic              err_r;

  logic                  in_range;
  logic                  wr_block;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_q;

  assign in_range = (addr_l[ADDR_W-1:DEPTH_LOG2] == '0);

`ifdef MEM_WRITE_PROTECT_EN
  assign wr_block = !in_range || (addr_l <= PROT_TOP);
`else
  assign wr_block = !in_range;
`endif

  // Address the RAM from the live bus in IDLE so ram_q already holds the
  // requested word by ACCESS, even with zero wait states.
  assign ram_addr = (state == IDLE) ? bus.addr[DEPTH_LOG2-1:0] : addr_l[DEPTH_LOG2-1:0];
  assign ram_we   = (state == ACCESS) && (op_l == OP_WR) && !wr_block && !reset;

  mem_array_sp #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_l),
    .rdata (ram_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      op_l    <= OP_RD;
      addr_l  <= '0;
      wdata_l <= '0;
      cnt     <= '0;
      rdata_r <= '0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.MR ^ bus.MW) begin
            addr_l  <= bus.addr;
            wdata_l <= bus.wdata;
            op_l    <= bus.MW ? OP_WR : OP_RD;
            cnt     <= WAIT_LD;
            busy_r  <= 1'b1;
            state   <= (WAIT_LD == '0) ? ACCESS : WAIT;
          end else if (bus.MR && bus.MW) begin
            err_r <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= WAIT_W'(1)) state <= ACCESS;
        end
        ACCESS: begin
          if (op_l == OP_RD) begin
            rdata_r <= in_range ? ram_q : '0;
            err_r   <= !in_range;
          end else begin
            err_r <= wr_block;
          end
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdata = rdata_r;
  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;
  assign bus.err   = err_r;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: one instance with 2 wait states, one with none,
// checked against a word-array reference model of the access rules.
module tb_mem_bus_ctrl;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_bus_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
  mem_bus_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();

  mem_bus_ctrl #(.WAIT_CYCLES(2)) dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));
  mem_bus_ctrl #(.WAIT_CYCLES(0)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem_m [2][256];
  logic [15:0] rd_m  [2];

  function automatic int exp_lat(input int w);
    return ((w == 0) ? 2 : 0) + 2;
  endfunction

  function automatic logic get_ready(input int w);
    return (w == 0) ? bus0.ready : bus1.ready;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic get_err(input int w);
    return (w == 0) ? bus0.err : bus1.err;
  endfunction
  function automatic logic [15:0] get_rdata(input int w);
    return (w == 0) ? bus0.rdata : bus1.rdata;
  endfunction

  task automatic set_req(input int w, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] d);
    if (w == 0) begin
      bus0.MR = rd; bus0.MW = wr; bus0.addr = a; bus0.wdata = d;
    end else begin
      bus1.MR = rd; bus1.MW = wr; bus1.addr = a; bus1.wdata = d;
    end
  endtask

  // Reference: addresses 0..255 exist; reads outside give 0 with err,
  // writes outside (or protected) are dropped with err; rdata only moves on reads.
  task automatic model(input int w, input logic rd, input logic [15:0] a, input logic [15:0] d,
                       output logic ee, output logic [15:0] eq);
    logic in_rng;
    logic prot;
    in_rng = (a < 16'd256);
`ifdef MEM_WRITE_PROTECT_EN
    prot = (a <= 16'h003F);
`else
    prot = 1'b0;
`endif
    if (rd) begin
      eq = in_rng ? mem_m[w][a[7:0]] : 16'h0000;
      rd_m[w] = eq;
      ee = !in_rng;
    end else begin
      ee = !in_rng || prot;
      if (!ee) mem_m[w][a[7:0]] = d;
      eq = rd_m[w];
    end
  endtask

  // Presents one request for a cycle, then waits (bounded) for ready.
  task automatic txn(input int w, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [15:0] d,
                     output int lat, output logic [15:0] q, output logic e, output logic busy_ok);
    lat = -1; q = '0; e = 1'b0; busy_ok = 1'b1;
    @(negedge clock); set_req(w, rd, wr, a, d);
    @(negedge clock); set_req(w, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      if (get_ready(w)) begin
        lat = k; q = get_rdata(w); e = get_err(w);
        if (get_busy(w)) busy_ok = 1'b0;
      end else begin
        if (!get_busy(w) || get_err(w)) busy_ok = 1'b0;
        @(negedge clock);
      end
    end
  endtask

  task automatic run_and_check(input string name, input int w, input logic rd,
                               input logic [15:0] a, input logic [15:0] d);
    int lat; logic [15:0] q; logic e; logic bok; logic ee; logic [15:0] eq;
    txn(w, rd, !rd, a, d, lat, q, e, bok);
    model(w, rd, a, d, ee, eq);
    n_checks++;
    if (lat !== exp_lat(w)) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat(w)); end
    n_checks++;
    if (bok !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %b expected 1", name, bok); end
    n_checks++;
    if (e !== ee) begin n_fail++; $display("FAIL %s err: got %b expected %b", name, e, ee); end
    n_checks++;
    if (q !== eq) begin n_fail++; $display("FAIL %s rdata: got %h expected %h", name, q, eq); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge clock);
    n_checks++;
    if ({bus0.rdata, bus0.ready, bus0.busy, bus0.err} !== 19'h0) begin
      n_fail++; $display("FAIL reset dut0: got %h expected 0", {bus0.rdata, bus0.ready, bus0.busy, bus0.err});
    end
    n_checks++;
    if ({bus1.rdata, bus1.ready, bus1.busy, bus1.err} !== 19'h0) begin
      n_fail++; $display("FAIL reset dut1: got %h expected 0", {bus1.rdata, bus1.ready, bus1.busy, bus1.err});
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    run_and_check("wr_0040", 0, 1'b0, 16'h0040, 16'hBEEF);
    run_and_check("rd_0040", 0, 1'b1, 16'h0040, 16'h0000);
    n_checks++;
    if (bus0.rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_0040 const: got %h expected beef", bus0.rdata); end
  endtask

  task automatic test_zero_wait();
    run_and_check("w0_wr_0010", 1, 1'b0, 16'h0010, 16'h1234);
    run_and_check("w0_rd_0010", 1, 1'b1, 16'h0010, 16'h0000);
    n_checks++;
    if (bus1.rdata !== 16'h1234) begin n_fail++; $display("FAIL w0_rd const: got %h expected 1234", bus1.rdata); end
  endtask

  task automatic test_both_strobes();
    @(negedge clock); set_req(0, 1'b1, 1'b1, 16'h0040, 16'hDEAD);
    @(negedge clock); set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n_checks++;
    if ({bus0.err, bus0.ready, bus0.busy} !== 3'b100) begin
      n_fail++; $display("FAIL both_strobes pulse: got err/ready/busy=%b expected 100", {bus0.err, bus0.ready, bus0.busy});
    end
    n_checks++;
    if (bus0.rdata !== rd_m[0]) begin n_fail++; $display("FAIL both_strobes rdata: got %h expected %h", bus0.rdata, rd_m[0]); end
    @(negedge clock);
    n_checks++;
    if ({bus0.err, bus0.ready, bus0.busy} !== 3'b000) begin
      n_fail++; $display("FAIL both_strobes idle: got err/ready/busy=%b expected 000", {bus0.err, bus0.ready, bus0.busy});
    end
    run_and_check("both_rd_0040", 0, 1'b1, 16'h0040, 16'h0000);
  endtask

  task automatic test_out_of_range();
    run_and_check("oor_rd_0100", 0, 1'b1, 16'h0100, 16'h0000);
    run_and_check("oor_wr_0100", 0, 1'b0, 16'h0100, 16'h9999);
    run_and_check("oor_rd_0000", 0, 1'b1, 16'h0000, 16'h0000);
    run_and_check("oor_rd_ffff", 0, 1'b1, 16'hFFFF, 16'h0000);
  endtask

  task automatic test_reset_mid_write();
    int seen;
    run_and_check("pre_rd_0040", 0, 1'b1, 16'h0040, 16'h0000);
    @(negedge clock); set_req(0, 1'b0, 1'b1, 16'h0050, 16'hAAAA);
    @(negedge clock); set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000); reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({bus0.rdata, bus0.ready, bus0.busy, bus0.err} !== 19'h0) begin
      n_fail++; $display("FAIL mid_reset outputs: got %h expected 0", {bus0.rdata, bus0.ready, bus0.busy, bus0.err});
    end
    reset = 1'b0;
    rd_m[0] = 16'h0000;
    rd_m[1] = 16'h0000;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus0.ready) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL mid_reset ready: got %0d pulses expected 0", seen); end
    run_and_check("post_rd_0050", 0, 1'b1, 16'h0050, 16'h0000);
  endtask

  task automatic test_protect();
    run_and_check("prot_wr_0020", 0, 1'b0, 16'h0020, 16'h5555);
    run_and_check("prot_rd_0020", 0, 1'b1, 16'h0020, 16'h0000);
    run_and_check("prot_wr_003f", 1, 1'b0, 16'h003F, 16'h6666);
    run_and_check("prot_rd_003f", 1, 1'b1, 16'h003F, 16'h0000);
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic ee; logic [15:0] eq;
    pulses = 0;
    @(negedge clock); set_req(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (bus0.ready) pulses++;
    end
    set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n_checks++;
    if (pulses !== 2) begin n_fail++; $display("FAIL back_to_back pulses: got %0d expected 2", pulses); end
    model(0, 1'b1, 16'h0040, 16'h0000, ee, eq);
    repeat (8) @(negedge clock);
    n_checks++;
    if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL back_to_back settle: busy %b expected 0", bus0.busy); end
    n_checks++;
    if (bus0.rdata !== eq) begin n_fail++; $display("FAIL back_to_back rdata: got %h expected %h", bus0.rdata, eq); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] d;
    logic        rd;
    int          w;
    for (int i = 0; i < 40; i++) begin
      w  = int'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      d  = 16'($urandom);
      run_and_check($sformatf("rand%0d", i), w, rd, a, d);
    end
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 256; i++) mem_m[w][i] = 16'h0000;
      rd_m[w] = 16'h0000;
    end
    test_reset();
    test_write_read();
    test_zero_wait();
    test_both_strobes();
    test_out_of_range();
    test_reset_mid_write();
    test_protect();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
